// File: rtl/design_42_pkg.sv
// Shared constants and types for the design_42 registered adder.
package design_42_pkg;

  // Default operand/result width.
  localparam int unsigned DefaultW = 12;

  // Controller states: StIdle = no result pending, StDone = result valid this cycle.
  typedef enum logic {
    StIdle = 1'b0,
    StDone = 1'b1
  } state_e;

endpackage

// File: rtl/design_42_adder.sv
// Combinational W-bit unsigned adder with carry out.
module design_42_adder #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] full_sum;

  // Zero-extend both operands so the carry lands in bit W.
  always_comb begin
    full_sum = {1'b0, a_i} + {1'b0, b_i};
    sum_o    = full_sum[W-1:0];
    carry_o  = full_sum[W];
  end

endmodule

// File: rtl/design_42.sv
// Registered adder with a two-state result-valid controller.
// Optional feature: define DESIGN_42_CARRY_EN to add a registered carry_out port.
module design_42
  import design_42_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
`ifdef DESIGN_42_CARRY_EN
  output logic         carry_out,
`endif
  output logic         valid
);

  state_e       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] sum;

`ifdef DESIGN_42_CARRY_EN
  logic carry;
  logic carry_q, carry_d;
`else
  // Carry is not exported in this build.
  logic carry_unused;
`endif

  design_42_adder #(
    .W (W)
  ) u_adder (
    .a_i     (a),
    .b_i     (b),
    .sum_o   (sum),
`ifdef DESIGN_42_CARRY_EN
    .carry_o (carry)
`else
    .carry_o (carry_unused)
`endif
  );

  // Controller next state: any start leads to StDone, otherwise back to StIdle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = start ? StDone : StIdle;
      StDone:  state_d = start ? StDone : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Result capture: load on start, hold otherwise.
  always_comb begin
    y_d = y_q;
    if (start) begin
      y_d = sum;
    end
  end

`ifdef DESIGN_42_CARRY_EN
  // Carry captured alongside the sum.
  always_comb begin
    carry_d = carry_q;
    if (start) begin
      carry_d = carry;
    end
  end
`endif

  // State and result registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

`ifdef DESIGN_42_CARRY_EN
  // Optional carry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign carry_out = carry_q;
`endif

  assign y     = y_q;
  assign valid = (state_q == StDone);

endmodule

// File: tb/tb_design_42.sv
// Directed self-checking bench for design_42 (W=12).
module tb_design_42;

  localparam int unsigned W = 12;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         valid;
`ifdef DESIGN_42_CARRY_EN
  logic         carry_out;
`endif

  int checks = 0;
  int errors = 0;

  design_42 #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .y         (y),
`ifdef DESIGN_42_CARRY_EN
    .carry_out (carry_out),
`endif
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra, rb, exp_y;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset held for 3 cycles.
    #1;
    chk("reset_t0_valid", 32'(valid), 0);
    chk("reset_t0_y", 32'(y), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_valid", 32'(valid), 0);
      chk("reset_y", 32'(y), 0);
    end
    rst_n = 1'b1;

    // Single op.
    a = 12'd1000; b = 12'd1000; start = 1'b1;
    tick();
    start = 1'b0;
    chk("single_valid", 32'(valid), 1);
    chk("single_y", 32'(y), 2000);
    tick();
    chk("single_valid_drop", 32'(valid), 0);
    chk("single_y_hold", 32'(y), 2000);
    a = 12'd7; b = 12'd7;
    tick();
    chk("single_y_hold2", 32'(y), 2000);

    // Wrap.
    a = 12'd4095; b = 12'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("wrap_valid", 32'(valid), 1);
    chk("wrap_y", 32'(y), 0);
`ifdef DESIGN_42_CARRY_EN
    chk("wrap_carry", 32'(carry_out), 1);
`endif
    tick();
    chk("wrap_valid_drop", 32'(valid), 0);
`ifdef DESIGN_42_CARRY_EN
    chk("wrap_carry_hold", 32'(carry_out), 1);
`endif

    // Back-to-back.
    a = 12'd1; b = 12'd2; start = 1'b1;
    tick();
    chk("b2b1_valid", 32'(valid), 1);
    chk("b2b1_y", 32'(y), 3);
`ifdef DESIGN_42_CARRY_EN
    chk("b2b1_carry", 32'(carry_out), 0);
`endif
    a = 12'd3; b = 12'd4;
    tick();
    chk("b2b2_valid", 32'(valid), 1);
    chk("b2b2_y", 32'(y), 7);
    a = 12'd5; b = 12'd6;
    tick();
    start = 1'b0;
    chk("b2b3_valid", 32'(valid), 1);
    chk("b2b3_y", 32'(y), 11);
    tick();
    chk("b2b_end_valid", 32'(valid), 0);
    chk("b2b_end_y", 32'(y), 11);

    // Asynchronous reset mid-cycle clears outputs immediately.
    a = 12'd100; b = 12'd200; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_async_valid", 32'(valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid), 0);
    chk("async_y", 32'(y), 0);
    tick();
    rst_n = 1'b1;

    // Reset mid-op: start then reset before the capturing edge.
    a = 12'd10; b = 12'd20; start = 1'b1;
    #3;
    rst_n = 1'b0;
    tick();
    chk("midop_valid", 32'(valid), 0);
    chk("midop_y", 32'(y), 0);
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midop_valid2", 32'(valid), 0);
    chk("midop_y2", 32'(y), 0);

    // Random ops; the first start lands on the first edge after reset release.
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 1023));
      rb = W'($urandom_range(0, 1023));
      exp_y = W'((32'(ra) + 32'(rb)) % 4096);
      a = ra; b = rb; start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom_range(0, 4095));
      b = W'($urandom_range(0, 4095));
      chk("rand_valid", 32'(valid), 1);
      chk("rand_y", 32'(y), 32'(exp_y));
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("rand_idle_valid", 32'(valid), 0);
        chk("rand_idle_y", 32'(y), 32'(exp_y));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/design_42.md
DESIGN_42 -- requirements
Module: design_42

Interface
REQ-001 The block SHALL have parameter W, default 12, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request strobe; a and b are sampled on the same edge.
REQ-005 The block SHALL have port a, input, W bits: first operand, unsigned.
REQ-006 The block SHALL have port b, input, W bits: second operand, unsigned.
REQ-007 The block SHALL have port y, output, W bits: registered sum result.
REQ-008 The block SHALL have port valid, output, 1 bit: result-valid pulse.

Function
REQ-009 The block SHALL, on a rising clk edge with start=1, capture y <= (a + b) mod 2^W, with the carry discarded from y.
REQ-010 The block SHALL assert valid in the cycle directly after any cycle with start=1 (latency 1), and deassert it after a cycle with start=0.
REQ-011 The block SHALL register both y and valid, with no combinational path from any input to any output.
REQ-012 The block SHALL hold y at its last captured value while start=0, and y SHALL remain stable while valid=0.
REQ-013 The block SHALL accept back-to-back starts with no backpressure: each start yields a fresh y, and valid stays high continuously.
REQ-014 The block SHALL implement a 2-state controller.
- State IDLE goes to DONE on start=1.
- State DONE goes to DONE on start=1 and to IDLE on start=0.
- valid = (state == DONE).
REQ-015 The block SHALL wrap on overflow: a=2^W-1 with b=1 gives y=0 with no error indication.
REQ-016 The block SHALL treat X/Z on start as illegal; while rst_n=1, start SHALL be known (0 or 1).

Reset
REQ-017 The block SHALL, while rst_n=0, force state=IDLE, valid=0, y=0 asynchronously, without waiting for a clk edge.
REQ-018 The block SHALL discard a start coinciding with or preceding reset assertion mid-operation; valid SHALL be 0 in every cycle during reset.
REQ-019 The block SHALL, on the first edge after rst_n rises, behave as IDLE; a start on that edge produces valid on the following cycle.

Configuration
REQ-020 The block SHALL support macro DESIGN_42_CARRY_EN.
- When defined: adds output port carry_out, 1 bit, registered alongside y, equal to bit W of (a + b) captured on start; reset value 0; held while start=0.
- When undefined: the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 Shared package design_42_pkg SHALL hold the default-width constant (12) and the controller state enum (IDLE, DONE).
REQ-022 The W-bit adder SHALL be a sub-module design_42_adder: combinational, W-bit sum and carry output, instantiated once.
REQ-023 The top level SHALL hold only the controller, the result registers, and optional carry register.

Verification
REQ-024 The bench SHALL cover these directed scenarios (W=12):
- Reset: hold rst_n=0 for 3 cycles -> valid=0 and y=0 throughout; assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately.
- Single op: a=1000, b=1000, start pulse -> next cycle valid=1, y=2000; following cycle valid=0, y still 2000.
- Wrap: a=4095, b=1, start -> y=0, valid=1; with DESIGN_42_CARRY_EN, carry_out=1.
- Back-to-back: starts on 3 consecutive cycles with (1,2), (3,4), (5,6) -> valid high 3 consecutive cycles, y=3, 7, 11 in turn.
- Reset mid-op: start with a=10, b=20, then rst_n=0 before the next edge -> valid never asserts, y=0.
- Random: 10 ops, operands in 0..1023, one start every 4 cycles -> valid exactly one cycle after each start, and y equals a scoreboard sum (a+b mod 4096).
